lib_switch_onehot_fifo: RTL and testbench

- NxM one-hot-select crossbar for packet_t, with a per-output FIFO of depth D and valid/ack handshakes on both sides.
- An input may be selected by several outputs. Such a multicast is accepted atomically, into all selecting outputs in the same cycle.
- Illegal (multi-hot) selects are detected and flagged per output.
- Sits between router input buffers and output links; it replaces the unbuffered/pipelined crossbar where downstream backpressure must be absorbed.

---
 rtl/lib_switch_onehot_fifo_pkg.sv | 9 +
 rtl/lib_fifo_packet_t.sv | 48 ++++
 rtl/lib_switch_onehot_fifo.sv | 84 ++++++++
 tb/tb_lib_switch_onehot_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lib_switch_onehot_fifo_pkg.sv
// Shared router types and switch constants used by the crossbar and its output FIFOs.
package lib_switch_onehot_fifo_pkg;
  localparam int SWITCH_FIFO_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [3:0]  src;
    logic [11:0] payload;
  } packet_t;
endpackage

// File: rtl/lib_fifo_packet_t.sv
// D-deep packet_t FIFO with occupancy count; storage is cleared on reset so the head reads 0.
module lib_fifo_packet_t
  import lib_switch_onehot_fifo_pkg::*;
#(
  parameter int D = SWITCH_FIFO_DEPTH_DEFAULT,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  packet_t       data_i,
  input  logic          pop_i,
  output packet_t       data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = $clog2(D);

  packet_t       mem_q [D];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(D));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/lib_switch_onehot_fifo.sv
// NxM one-hot-select crossbar with per-output FIFOs; multicast pushes are all-or-nothing.
module lib_switch_onehot_fifo
  import lib_switch_onehot_fifo_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4,
  parameter int D = SWITCH_FIFO_DEPTH_DEFAULT,
  localparam int CW = $clog2(D + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [0:M-1][0:N-1]     i_sel,
  input  packet_t [0:N-1]         i_data,
  input  logic [0:N-1]            i_data_val,
  output logic [0:N-1]            o_data_ack,
  output packet_t [0:M-1]         o_data,
  output logic [0:M-1]            o_data_val,
  input  logic [0:M-1]            i_data_ack,
  output logic [0:M-1]            o_sel_err,
  output logic [0:M-1][CW-1:0]    o_count
);
  logic [0:M-1]    legal, multi, push, full, empty;
  logic [0:M-1]    sel_err_q, sel_err_d;
  logic [0:N-1]    sel_any, sel_blk;
  packet_t [0:M-1] push_data;

  always_comb begin
    for (int m = 0; m < M; m++) begin
      legal[m] = $onehot(i_sel[m]);
      multi[m] = (|i_sel[m]) & ~legal[m];
    end
  end

  // Ready looks only at registered full flags, so a same-cycle pop never unblocks a push.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      sel_any[j] = 1'b0;
      sel_blk[j] = 1'b0;
      for (int m = 0; m < M; m++) begin
        if (legal[m] && i_sel[m][j]) begin
          sel_any[j] = 1'b1;
          sel_blk[j] = sel_blk[j] | full[m];
        end
      end
      o_data_ack[j] = reset_n & i_data_val[j] & sel_any[j] & ~sel_blk[j];
    end
  end

  always_comb begin
    for (int m = 0; m < M; m++) begin
      push[m]      = 1'b0;
      push_data[m] = '0;
      for (int j = 0; j < N; j++) begin
        if (legal[m] && i_sel[m][j]) begin
          push[m]      = o_data_ack[j];
          push_data[m] = i_data[j];
        end
      end
    end
  end

  assign sel_err_d = multi;
  assign o_sel_err = sel_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sel_err_q <= '0;
    else          sel_err_q <= sel_err_d;
  end

  for (genvar m = 0; m < M; m++) begin : g_out
    lib_fifo_packet_t #(.D(D)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push[m]),
      .data_i  (push_data[m]),
      .pop_i   (i_data_ack[m]),
      .data_o  (o_data[m]),
      .count_o (o_count[m]),
      .empty_o (empty[m]),
      .full_o  (full[m])
    );
    assign o_data_val[m] = ~empty[m];
  end
endmodule

// File: tb/tb_lib_switch_onehot_fifo.sv
// Directed bench for the one-hot crossbar FIFO: unicast, multicast, backpressure, wrap, errors, reset.
module tb_lib_switch_onehot_fifo;
  import lib_switch_onehot_fifo_pkg::*;

  logic                clk;
  logic                reset_n;
  logic [0:3][0:3]     i_sel;
  packet_t [0:3]       i_data;
  logic [0:3]          i_data_val;
  logic [0:3]          o_data_ack;
  packet_t [0:3]       o_data;
  logic [0:3]          o_data_val;
  logic [0:3]          i_data_ack;
  logic [0:3]          o_sel_err;
  logic [0:3][2:0]     o_count;

  int checks = 0;
  int errors = 0;

  lib_switch_onehot_fifo #(.N(4), .M(4), .D(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_sel      (i_sel),
    .i_data     (i_data),
    .i_data_val (i_data_val),
    .o_data_ack (o_data_ack),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .i_data_ack (i_data_ack),
    .o_sel_err  (o_sel_err),
    .o_count    (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    i_sel      = '0;
    i_data     = '0;
    i_data_val = '0;
    i_data_ack = '0;
  endtask

  initial begin
    clr();
    reset_n    = 1'b0;
    i_sel[0]   = 4'b1000;
    i_data_val = 4'b1111;
    #1;
    chk("rst_ack", 32'(o_data_ack), 32'h0);
    chk("rst_count", 32'(o_count), 32'h0);
    chk("rst_val", 32'(o_data_val), 32'h0);
    chk("rst_err", 32'(o_sel_err), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clr();

    // Unicast: input 1 -> output 2
    i_sel[2] = 4'b0100; i_data[1] = 16'hA1A1; i_data_val[1] = 1'b1;
    #1 chk("uni_ack", 32'(o_data_ack), 32'(4'b0100));
    @(negedge clk);
    clr();
    chk("uni_val", 32'(o_data_val), 32'(4'b0010));
    chk("uni_data", 32'(o_data[2]), 32'hA1A1);
    chk("uni_count", 32'(o_count[2]), 32'd1);
    i_data_ack[2] = 1'b1;
    @(negedge clk);
    clr();
    chk("uni_pop_count", 32'(o_count[2]), 32'd0);

    // Multicast: input 0 -> outputs 0 and 3
    i_sel[0] = 4'b1000; i_sel[3] = 4'b1000; i_data[0] = 16'hB0B0; i_data_val[0] = 1'b1;
    #1 chk("mc_ack", 32'(o_data_ack), 32'(4'b1000));
    @(negedge clk);
    clr();
    chk("mc_val", 32'(o_data_val), 32'(4'b1001));
    chk("mc_data0", 32'(o_data[0]), 32'hB0B0);
    chk("mc_data3", 32'(o_data[3]), 32'hB0B0);
    chk("mc_counts", {o_count[0], o_count[3]}, 32'(6'b001_001));
    i_data_ack = 4'b1001;
    @(negedge clk);
    clr();
    chk("mc_drained", 32'(o_data_val), 32'h0);

    // Backpressure: input 2 -> output 1, no pops
    i_sel[1] = 4'b0010; i_data_val[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data[2] = 16'h0301 + 16'(k);
      #1 chk("full_ack", 32'(o_data_ack), 32'(4'b0010));
      @(negedge clk);
    end
    i_data[2] = 16'h0305;
    #1 chk("full_hold_ack", 32'(o_data_ack), 32'h0);
    chk("full_count", 32'(o_count[1]), 32'd4);
    i_data_ack[1] = 1'b1;
    #1 chk("full_pop_blocks", 32'(o_data_ack), 32'h0);
    @(negedge clk);
    i_data_ack[1] = 1'b0;
    chk("after_pop_count", 32'(o_count[1]), 32'd3);
    chk("after_pop_head", 32'(o_data[1]), 32'h0302);
    chk("fifth_ack", 32'(o_data_ack), 32'(4'b0010));
    @(negedge clk);
    clr();
    chk("refill_count", 32'(o_count[1]), 32'd4);

    // Multicast where only output 1 is full: nothing may be written
    i_sel[0] = 4'b0001; i_sel[1] = 4'b0001; i_data[3] = 16'h0BAD; i_data_val[3] = 1'b1;
    #1 chk("mcfull_ack", 32'(o_data_ack), 32'h0);
    @(negedge clk);
    clr();
    chk("mcfull_count0", 32'(o_count[0]), 32'd0);
    chk("mcfull_count1", 32'(o_count[1]), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("drain1_order", 32'(o_data[1]), 32'h0302 + 32'(k));
      i_data_ack[1] = 1'b1;
      @(negedge clk);
    end
    clr();
    chk("drain1_count", 32'(o_count[1]), 32'd0);

    // Simultaneous push/pop at count 2 with pointer wrap: input 2 -> output 3
    i_sel[3] = 4'b0010; i_data_val[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_data[2] = 16'h0400 + 16'(k);
      @(negedge clk);
    end
    for (int k = 2; k < 10; k++) begin
      chk("pp_count", 32'(o_count[3]), 32'd2);
      chk("pp_order", 32'(o_data[3]), 32'h0400 + 32'(k - 2));
      i_data[2] = 16'h0400 + 16'(k);
      i_data_ack[3] = 1'b1;
      @(negedge clk);
    end
    i_data_val = '0;
    chk("pp_tail8", 32'(o_data[3]), 32'h0408);
    @(negedge clk);
    chk("pp_tail9", 32'(o_data[3]), 32'h0409);
    @(negedge clk);
    clr();
    chk("pp_empty", 32'(o_count[3]), 32'd0);

    // Illegal multi-hot select on output 1
    chk("err_idle_pre", 32'(o_sel_err), 32'h0);
    i_sel[1] = 4'b0110; i_data_val = 4'b1111; i_data[1] = 16'h0E01; i_data[2] = 16'h0E02;
    #1 chk("err_ack", 32'(o_data_ack), 32'h0);
    @(negedge clk);
    clr();
    chk("err_flag", 32'(o_sel_err), 32'(4'b0100));
    chk("err_nopush", 32'(o_count[1]), 32'd0);
    @(negedge clk);
    chk("err_clear", 32'(o_sel_err), 32'h0);

    // Build counts {3,1,0,4} then reset asynchronously mid-cycle
    i_data_val[0] = 1'b1;
    i_sel[0] = 4'b1000; i_sel[1] = 4'b1000; i_sel[3] = 4'b1000; i_data[0] = 16'h0601;
    @(negedge clk);
    i_sel[1] = 4'b0000; i_data[0] = 16'h0602;
    @(negedge clk);
    i_data[0] = 16'h0603;
    @(negedge clk);
    i_sel[0] = 4'b0000; i_sel[2] = 4'b1100; i_data[0] = 16'h0604;
    @(negedge clk);
    clr();
    chk("pre_rst_counts", 32'(o_count), 32'(12'b011_001_000_100));
    chk("pre_rst_err", 32'(o_sel_err), 32'(4'b0010));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(o_count), 32'h0);
    chk("arst_val", 32'(o_data_val), 32'h0);
    chk("arst_err", 32'(o_sel_err), 32'h0);
    chk("arst_data", 32'(o_data[0]), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    i_sel[0] = 4'b0100; i_data[1] = 16'h0C0C; i_data_val[1] = 1'b1;
    #1 chk("post_rst_ack", 32'(o_data_ack), 32'(4'b0100));
    @(negedge clk);
    clr();
    chk("post_rst_val", 32'(o_data_val), 32'(4'b1000));
    chk("post_rst_data", 32'(o_data[0]), 32'h0C0C);
    chk("post_rst_count", 32'(o_count[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
